// File: rtl/ctrl_pkg.sv
// Shared types and opcode constants for the multi-cycle controller.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [1:0] {
        CLS_ARITH,
        CLS_MOVE,
        CLS_NOP,
        CLS_HALT
    } instr_class_t;

    // Value of the opcode MSB that marks an arithmetic instruction.
    localparam logic       OPCODE_ARITHMETIC_BIT = 1'b0;
    localparam logic [3:0] OPCODE_NOP            = 4'b1000;
    localparam logic [3:0] OPCODE_MOVE           = 4'b1001;
    localparam logic [3:0] OPCODE_HALT           = 4'b1111;

    localparam int CNT_W = 4;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational instruction decode: IR -> instruction class and field slices.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int IW   = 8,
    parameter int OPW  = 4,
    parameter int AOPW = 3,
    parameter int SHW  = 3
) (
    input  logic [IW-1:0]     ir,
    output instr_class_t      cls,
    output logic [AOPW-1:0]   alu_op,
    output logic [SHW-1:0]    alu_shamt,
    output logic [IW-OPW-1:0] reg_sel,
    output logic [1:0]        reg16_src,
    output logic [1:0]        reg16_dst
);

    logic [OPW-1:0]    opcode;
    logic [IW-OPW-1:0] operand;

    assign opcode  = ir[IW-1 -: OPW];
    assign operand = ir[IW-OPW-1:0];

    // Any non-arithmetic opcode that is not MOVE or HALT behaves as NOP.
    always_comb begin
        cls = CLS_NOP;
        if (opcode[OPW-1] == OPCODE_ARITHMETIC_BIT) begin
            cls = CLS_ARITH;
        end else if (opcode == OPW'(OPCODE_MOVE)) begin
            cls = CLS_MOVE;
        end else if (opcode == OPW'(OPCODE_HALT)) begin
            cls = CLS_HALT;
        end else if (opcode == OPW'(OPCODE_NOP)) begin
            cls = CLS_NOP;
        end
    end

    assign alu_op    = opcode[AOPW-1:0];
    assign alu_shamt = operand[SHW-1:0];
    assign reg_sel   = operand;
    assign reg16_src = operand[3:2];
    assign reg16_dst = operand[1:0];

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/WB controller: owns the IR, the FSM and the ALU latency counter.
module ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int IW      = 8,
    parameter int OPW     = 4,
    parameter int AOPW    = 3,
    parameter int SHW     = 3,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              fetch_req,
    input  logic              fetch_ack,
    input  logic [IW-1:0]     instr,
    input  logic              stall,
    output logic [AOPW-1:0]   alu_op,
    output logic [SHW-1:0]    alu_shamt,
    output logic              alu_en,
    output logic [IW-OPW-1:0] reg_sel,
    output logic [1:0]        reg16_src,
    output logic [1:0]        reg16_dst,
    output logic              reg_we,
    output logic              busy,
    output logic              halted
);

    state_t            state_q, state_d;
    logic [IW-1:0]     ir_q, ir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              fetch_req_q, fetch_req_d;
    logic              alu_en_q, alu_en_d;
    logic              reg_we_q, reg_we_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;
    instr_class_t      cls;

    ctrl_decode #(
        .IW   (IW),
        .OPW  (OPW),
        .AOPW (AOPW),
        .SHW  (SHW)
    ) u_decode (
        .ir        (ir_q),
        .cls       (cls),
        .alu_op    (alu_op),
        .alu_shamt (alu_shamt),
        .reg_sel   (reg_sel),
        .reg16_src (reg16_src),
        .reg16_dst (reg16_dst)
    );

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (fetch_ack) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!stall) begin
                    unique case (cls)
                        CLS_ARITH: begin
                            state_d = S_EXEC;
                            cnt_d   = CNT_W'(ALU_LAT - 1);
                        end
                        CLS_MOVE: state_d = S_WB;
                        CLS_HALT: state_d = S_HALT;
                        default:  state_d = S_FETCH;
                    endcase
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase

        // Outputs are registered alongside the state so they change on the same edge.
        fetch_req_d = (state_d == S_FETCH);
        alu_en_d    = (state_q == S_DECODE) && (state_d == S_EXEC);
        reg_we_d    = (state_d == S_WB);
        busy_d      = (state_d != S_IDLE) && (state_d != S_HALT);
        halted_d    = (state_d == S_HALT);
    end

    // NOTE: reset is synchronous and takes priority; all state updates use non-blocking assignment.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ir_q        <= '0;
            cnt_q       <= '0;
            fetch_req_q <= 1'b0;
            alu_en_q    <= 1'b0;
            reg_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            cnt_q       <= cnt_d;
            fetch_req_q <= fetch_req_d;
            alu_en_q    <= alu_en_d;
            reg_we_q    <= reg_we_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
        end
    end

    assign fetch_req = fetch_req_q;
    assign alu_en    = alu_en_q;
    assign reg_we    = reg_we_q;
    assign busy      = busy_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Randomized bench for ctrl_seq against a timeline model derived from the instruction latencies.
module tb_ctrl_seq;

    localparam int IW      = 8;
    localparam int OPW     = 4;
    localparam int AOPW    = 3;
    localparam int SHW     = 3;
    localparam int ALU_LAT = 3;

    localparam logic [4:0] C_FETCH = 5'b10010;
    localparam logic [4:0] C_DEC   = 5'b00010;
    localparam logic [4:0] C_ALU   = 5'b01010;
    localparam logic [4:0] C_WB    = 5'b00110;
    localparam logic [4:0] C_HALT  = 5'b00001;
    localparam logic [4:0] C_ZERO  = 5'b00000;

    logic              clk = 1'b0;
    logic              rst;
    logic              fetch_req;
    logic              fetch_ack;
    logic [IW-1:0]     instr;
    logic              stall;
    logic [AOPW-1:0]   alu_op;
    logic [SHW-1:0]    alu_shamt;
    logic              alu_en;
    logic [IW-OPW-1:0] reg_sel;
    logic [1:0]        reg16_src;
    logic [1:0]        reg16_dst;
    logic              reg_we;
    logic              busy;
    logic              halted;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  model_ir;

    ctrl_seq #(
        .IW      (IW),
        .OPW     (OPW),
        .AOPW    (AOPW),
        .SHW     (SHW),
        .ALU_LAT (ALU_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fetch_req (fetch_req),
        .fetch_ack (fetch_ack),
        .instr     (instr),
        .stall     (stall),
        .alu_op    (alu_op),
        .alu_shamt (alu_shamt),
        .alu_en    (alu_en),
        .reg_sel   (reg_sel),
        .reg16_src (reg16_src),
        .reg16_dst (reg16_dst),
        .reg_we    (reg_we),
        .busy      (busy),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [4:0] ctl();
        return {fetch_req, alu_en, reg_we, busy, halted};
    endfunction

    function automatic logic [13:0] fields();
        return {alu_op, alu_shamt, reg_sel, reg16_src, reg16_dst};
    endfunction

    // 0 = arithmetic, 1 = move, 2 = nop (incl. unknown), 3 = halt
    function automatic int classify(input logic [7:0] ins);
        int op = int'(ins) / 16;
        if (op < 8)   return 0;
        if (op == 9)  return 1;
        if (op == 15) return 3;
        return 2;
    endfunction

    function automatic logic [13:0] exp_fields(input logic [7:0] ins);
        int op  = int'(ins) / 16;
        int opd = int'(ins) % 16;
        return {3'(op % 8), 3'(opd % 8), 4'(opd), 2'(opd / 4), 2'(opd % 4)};
    endfunction

    // Expected controls k cycles after the ack cycle, with s stall cycles in DECODE.
    function automatic logic [4:0] exp_ctl(input int cls, input int k, input int s);
        if (k <= 1 + s) return C_DEC;
        case (cls)
            0: begin
                if (k == 2 + s)           return C_ALU;
                if (k <= 1 + s + ALU_LAT) return C_DEC;
                return C_WB;
            end
            1:       return C_WB;
            3:       return C_HALT;
            default: return C_DEC;
        endcase
    endfunction

    // Offset of the next fetch cycle after the ack (halt: how long to observe).
    function automatic int end_off(input int cls, input int s);
        case (cls)
            0:       return 3 + s + ALU_LAT;
            1:       return 3 + s;
            3:       return 10 + s;
            default: return 2 + s;
        endcase
    endfunction

    task automatic do_reset(input int n);
        rst       = 1'b1;
        fetch_ack = 1'b1;
        stall     = 1'b0;
        for (int i = 0; i < n; i++) begin
            instr = 8'($urandom);
            step();
            check($sformatf("reset_ctl c%0d", i), 32'(ctl()), 32'(C_ZERO));
            check($sformatf("reset_fields c%0d", i), 32'(fields()), 32'(0));
        end
        rst       = 1'b0;
        fetch_ack = 1'b0;
        step();
        model_ir = 8'h00;
        check("post_reset_fetch", 32'(ctl()), 32'(C_FETCH));
        check("post_reset_ir", 32'(fields()), 32'(0));
    endtask

    // Entered at a cycle where fetch_req should be high; returns at the next fetch cycle.
    task automatic run_instr(input logic [7:0] ins, input int delay, input int s);
        int cls;
        int e;
        for (int i = 0; i < delay; i++) begin
            check($sformatf("fetch_wait_ctl %0d", i), 32'(ctl()), 32'(C_FETCH));
            check($sformatf("ir_hold %0d", i), 32'(fields()), 32'(exp_fields(model_ir)));
            fetch_ack = 1'b0;
            instr     = 8'($urandom);
            stall     = 1'($urandom);
            step();
        end
        check("fetch_ctl", 32'(ctl()), 32'(C_FETCH));
        fetch_ack = 1'b1;
        instr     = ins;
        step();
        model_ir = ins;
        cls      = classify(ins);
        e        = end_off(cls, s);
        for (int k = 1; k < e; k++) begin
            check($sformatf("ctl %02h k=%0d", ins, k), 32'(ctl()), 32'(exp_ctl(cls, k, s)));
            check($sformatf("fields %02h k=%0d", ins, k), 32'(fields()), 32'(exp_fields(ins)));
            fetch_ack = 1'($urandom);
            instr     = 8'($urandom);
            if (k <= s)          stall = 1'b1;
            else if (k == s + 1) stall = 1'b0;
            else                 stall = 1'($urandom);
            step();
        end
        fetch_ack = 1'b0;
        stall     = 1'b0;
    endtask

    initial begin
        logic [7:0] ins;
        rst       = 1'b1;
        fetch_ack = 1'b1;
        stall     = 1'b0;
        instr     = 8'h00;
        model_ir  = 8'h00;

        do_reset(3);

        run_instr(8'h25, 0, 0);
        check("alu_op_25", 32'(alu_op), 32'(3'd2));
        check("alu_shamt_25", 32'(alu_shamt), 32'(3'd5));

        run_instr(8'h9B, 0, 0);
        check("reg16_src_9b", 32'(reg16_src), 32'(2'd2));
        check("reg16_dst_9b", 32'(reg16_dst), 32'(2'd3));

        run_instr(8'h47, 4, 0);
        run_instr(8'h13, 0, 2);
        run_instr(8'h80, 1, 0);
        run_instr(8'hA3, 0, 1);

        for (int n = 0; n < 40; n++) begin
            ins = 8'($urandom);
            if (classify(ins) == 3) ins = ins ^ 8'h10;
            run_instr(ins, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        run_instr(8'hF0, 2, 0);

        // Fresh run, then reset while the ALU op is in flight.
        do_reset(2);
        fetch_ack = 1'b1;
        instr     = 8'h31;
        step();
        fetch_ack = 1'b0;
        check("midexec_decode", 32'(ctl()), 32'(C_DEC));
        step();
        check("midexec_alu_en", 32'(ctl()), 32'(C_ALU));
        rst       = 1'b1;
        fetch_ack = 1'b1;
        step();
        check("midexec_rst_ctl", 32'(ctl()), 32'(C_ZERO));
        check("midexec_rst_ir", 32'(fields()), 32'(0));
        rst       = 1'b0;
        fetch_ack = 1'b0;
        step();
        check("midexec_refetch", 32'(ctl()), 32'(C_FETCH));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
